// File: rtl/puf_eval_sequencer.sv
// PUF evaluation sequencer: streams PDL configuration bytes in per response bit,
// triggers each evaluation, collects the response vector and writes it out bytewise.
module puf_eval_sequencer #(
  parameter int NUM_BITS             = 64,
  parameter int CFG_BYTES            = 16,
  parameter int TIMEOUT              = 255,
  parameter int INMEM_ADDRESS_WIDTH  = 17,
  parameter int OUTMEM_ADDRESS_WIDTH = 13
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  output logic                            busy,
  output logic                            done,
  output logic                            timeoutErr,
  output logic                            inputMemoryReadReq,
  input  logic                            inputMemoryReadAck,
  output logic [INMEM_ADDRESS_WIDTH-1:0]  inputMemoryReadAdd,
  input  logic                            inputMemoryReadDataValid,
  input  logic [7:0]                      inputMemoryReadData,
  output logic                            outputMemoryWriteReq,
  input  logic                            outputMemoryWriteAck,
  output logic [OUTMEM_ADDRESS_WIDTH-1:0] outputMemoryWriteAdd,
  output logic [7:0]                      outputMemoryWriteData,
  output logic [8*CFG_BYTES-1:0]          pufConfig,
  output logic [7:0]                      pufBitIndex,
  output logic                            pufStart,
  input  logic                            pufDone,
  input  logic                            pufResponse
);

  localparam int BCW = (CFG_BYTES > 1) ? $clog2(CFG_BYTES) : 1;
  localparam int NWB = NUM_BITS / 8;
  localparam int WIW = (NWB > 1) ? $clog2(NWB) : 1;
  localparam int TCW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    EVAL_START,
    EVAL_WAIT,
    WR_REQ,
    FINISH
  } state_t;

  state_t                 state_q, state_d;
  logic [7:0]             bit_q, bit_d;
  logic [BCW-1:0]         byte_q, byte_d;
  logic [8*CFG_BYTES-1:0] cfg_q, cfg_d;
  logic [NUM_BITS-1:0]    resp_q, resp_d;
  logic                   terr_q, terr_d;
  logic [TCW-1:0]         tcnt_q, tcnt_d;
  logic [WIW-1:0]         widx_q, widx_d;
  logic                   eval_exit;
  logic [7:0]             wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bit_q   <= '0;
      byte_q  <= '0;
      cfg_q   <= '0;
      resp_q  <= '0;
      terr_q  <= 1'b0;
      tcnt_q  <= '0;
      widx_q  <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      cfg_q   <= cfg_d;
      resp_q  <= resp_d;
      terr_q  <= terr_d;
      tcnt_q  <= tcnt_d;
      widx_q  <= widx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    cfg_d     = cfg_q;
    resp_d    = resp_q;
    terr_d    = terr_q;
    tcnt_d    = tcnt_q;
    widx_d    = widx_q;
    eval_exit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RD_REQ;
          bit_d   = '0;
          byte_d  = '0;
          terr_d  = 1'b0;
          resp_d  = '0;
        end
      end
      RD_REQ: begin
        if (inputMemoryReadAck) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (inputMemoryReadDataValid) begin
          for (int k = 0; k < CFG_BYTES; k++) begin
            if (byte_q == BCW'(k)) cfg_d[8*k +: 8] = inputMemoryReadData;
          end
          if (byte_q == BCW'(CFG_BYTES - 1)) begin
            state_d = EVAL_START;
          end else begin
            byte_d  = byte_q + BCW'(1);
            state_d = RD_REQ;
          end
        end
      end
      EVAL_START: begin
        tcnt_d  = '0;
        state_d = EVAL_WAIT;
      end
      EVAL_WAIT: begin
        // a done on the final counted cycle wins over the timeout
        if (pufDone) begin
          for (int i = 0; i < NUM_BITS; i++) begin
            if (bit_q == 8'(i)) resp_d[i] = pufResponse;
          end
          eval_exit = 1'b1;
        end else if (tcnt_q == TCW'(TIMEOUT - 1)) begin
          for (int i = 0; i < NUM_BITS; i++) begin
            if (bit_q == 8'(i)) resp_d[i] = 1'b0;
          end
          terr_d    = 1'b1;
          eval_exit = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TCW'(1);
        end
        if (eval_exit) begin
          if (bit_q == 8'(NUM_BITS - 1)) begin
            widx_d  = '0;
            state_d = WR_REQ;
          end else begin
            bit_d   = bit_q + 8'd1;
            byte_d  = '0;
            state_d = RD_REQ;
          end
        end
      end
      WR_REQ: begin
        if (outputMemoryWriteAck) begin
          if (widx_q == WIW'(NWB - 1)) state_d = FINISH;
          else widx_d = widx_q + WIW'(1);
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wdata = '0;
    for (int j = 0; j < NWB; j++) begin
      if (widx_q == WIW'(j)) wdata = resp_q[8*j +: 8];
    end
  end

  assign busy                  = (state_q != IDLE);
  assign done                  = (state_q == FINISH);
  assign timeoutErr            = terr_q;
  assign inputMemoryReadReq    = (state_q == RD_REQ);
  assign inputMemoryReadAdd    = INMEM_ADDRESS_WIDTH'(bit_q) *
                                 INMEM_ADDRESS_WIDTH'(CFG_BYTES) +
                                 INMEM_ADDRESS_WIDTH'(byte_q);
  assign outputMemoryWriteReq  = (state_q == WR_REQ);
  assign outputMemoryWriteAdd  = OUTMEM_ADDRESS_WIDTH'(widx_q);
  assign outputMemoryWriteData = wdata;
  assign pufConfig             = cfg_q;
  assign pufBitIndex           = bit_q;
  assign pufStart              = (state_q == EVAL_START);

endmodule

// File: tb/tb_puf_eval_sequencer.sv
// Directed bench for puf_eval_sequencer: table of run scenarios plus
// hand-written reset-during-write sequence.
module tb_puf_eval_sequencer;

  localparam int NB = 8;
  localparam int CB = 16;
  localparam int TO = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         busy, done, timeoutErr;
  logic         rd_req, rd_ack, rd_v;
  logic [16:0]  rd_add;
  logic [7:0]   rd_data;
  logic         wr_req, wr_ack;
  logic [12:0]  wr_add;
  logic [7:0]   wr_data;
  logic [127:0] cfg;
  logic [7:0]   bidx;
  logic         p_start, p_done_w, p_resp_w;

  logic r_ack = 0, r_v = 0, w_ack = 0, p_done = 0, p_resp = 0;
  logic man_rack = 0, man_rv = 0, man_wack = 0;
  logic inj_done = 0, inj_resp = 0;
  logic [7:0] r_data = 0;

  assign rd_ack   = r_ack | man_rack;
  assign rd_v     = r_v | man_rv;
  assign rd_data  = r_data;
  assign wr_ack   = w_ack | man_wack;
  assign p_done_w = p_done | inj_done;
  assign p_resp_w = inj_done ? inj_resp : p_resp;

  always #5 clk = ~clk;

  puf_eval_sequencer #(
    .NUM_BITS(NB), .CFG_BYTES(CB), .TIMEOUT(TO),
    .INMEM_ADDRESS_WIDTH(17), .OUTMEM_ADDRESS_WIDTH(13)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done), .timeoutErr(timeoutErr),
    .inputMemoryReadReq(rd_req), .inputMemoryReadAck(rd_ack),
    .inputMemoryReadAdd(rd_add),
    .inputMemoryReadDataValid(rd_v), .inputMemoryReadData(rd_data),
    .outputMemoryWriteReq(wr_req), .outputMemoryWriteAck(wr_ack),
    .outputMemoryWriteAdd(wr_add), .outputMemoryWriteData(wr_data),
    .pufConfig(cfg), .pufBitIndex(bidx), .pufStart(p_start),
    .pufDone(p_done_w), .pufResponse(p_resp_w)
  );

  typedef struct {
    int         rd_dly;
    int         wr_dly;
    int         nodone;
    bit         spur;
    logic [7:0] exp_byte;
    int         exp_terr;
    int         exp_gap;
  } vec_t;

  vec_t tbl[4];

  int rd_dly = 0, wr_dly = 0, nodone_bit = -1;
  int rd_cnt = 0, seq_err = 0, stab_err = 0, wr_cnt = 0, done_cnt = 0;
  int cyc = 0, s3 = -1, r4 = -1;
  int rw = 0, vcnt = 0, ww = 0, pcnt = 0;
  logic [16:0]  ra = 0, ra_first = 0;
  logic [12:0]  wa_first = 0, wr_add_log = 0;
  logic [7:0]   wd_first = 0, wr_data_log = 0, pbit = 0;
  logic [127:0] cfg_cap = 0, exp_cfg;
  logic         terr_done = 0;
  int n_chk = 0, n_fail = 0;

  // read memory: byte at address n is n, data 2 cycles after ack
  always @(negedge clk) begin
    r_v = 1'b0;
    if (vcnt > 0) begin
      vcnt--;
      if (vcnt == 0) begin
        r_v    = 1'b1;
        r_data = ra[7:0];
      end
    end
    r_ack = 1'b0;
    if (rd_req && !reset) begin
      if (rw == 0) ra_first = rd_add;
      else if (rd_add != ra_first) stab_err++;
      if (rw >= rd_dly) begin
        r_ack = 1'b1;
        vcnt  = 2;
        ra    = rd_add;
        if (rd_add != 17'(rd_cnt)) seq_err++;
        rd_cnt++;
        rw = 0;
      end else rw++;
    end else rw = 0;
  end

  always @(negedge clk) begin
    w_ack = 1'b0;
    if (wr_req && !reset) begin
      if (ww == 0) begin
        wa_first = wr_add;
        wd_first = wr_data;
      end else if (wr_add != wa_first || wr_data != wd_first) stab_err++;
      if (ww >= wr_dly) begin
        w_ack       = 1'b1;
        wr_add_log  = wr_add;
        wr_data_log = wr_data;
        wr_cnt++;
        ww = 0;
      end else ww++;
    end else ww = 0;
  end

  // PUF model: response = bitIndex[0], one cycle after pufStart
  always @(negedge clk) begin
    p_done = 1'b0;
    if (pcnt > 0) begin
      pcnt--;
      if (pcnt == 0) begin
        p_done = 1'b1;
        p_resp = pbit[0];
      end
    end
    if (p_start) begin
      pbit = bidx;
      if (int'(bidx) != nodone_bit) pcnt = 1;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (done) begin
      done_cnt++;
      terr_done = timeoutErr;
    end
    if (p_start && bidx == 8'd1) cfg_cap = cfg;
    if (p_start && bidx == 8'd3) s3 = cyc;
    if (rd_req && bidx == 8'd4 && r4 < 0) r4 = cyc;
  end

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic checkw(input string name, input logic [127:0] got,
                        input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic clear_mon();
    rd_cnt = 0; seq_err = 0; stab_err = 0; wr_cnt = 0; done_cnt = 0;
    s3 = -1; r4 = -1; cfg_cap = '0; terr_done = 1'b0;
    wr_add_log = '1; wr_data_log = '0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_one(input int i);
    int k;
    rd_dly     = tbl[i].rd_dly;
    wr_dly     = tbl[i].wr_dly;
    nodone_bit = tbl[i].nodone;
    clear_mon();
    pulse_start();
    repeat (3) @(negedge clk);
    check($sformatf("r%0d_terr_clr", i), int'(timeoutErr), 0);
    check($sformatf("r%0d_busy", i), int'(busy), 1);
    if (tbl[i].spur) begin
      k = 0;
      while (!(bidx == 8'd1 && rd_req) && k < 2000) begin
        @(negedge clk);
        k++;
      end
      @(negedge clk);
      inj_done = 1'b1;
      inj_resp = 1'b0;
      start    = 1'b1;
      @(negedge clk);
      inj_done = 1'b0;
      start    = 1'b0;
    end
    k = 0;
    while (done_cnt == 0 && k < 6000) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("r%0d_done_seen", i), int'(done_cnt > 0), 1);
    repeat (3) @(negedge clk);
    check($sformatf("r%0d_reads", i), rd_cnt, NB * CB);
    check($sformatf("r%0d_rd_seq", i), seq_err, 0);
    check($sformatf("r%0d_stable", i), stab_err, 0);
    check($sformatf("r%0d_writes", i), wr_cnt, 1);
    check($sformatf("r%0d_wr_add", i), int'(wr_add_log), 0);
    check($sformatf("r%0d_wr_data", i), int'(wr_data_log), int'(tbl[i].exp_byte));
    check($sformatf("r%0d_done_cnt", i), done_cnt, 1);
    check($sformatf("r%0d_terr_done", i), int'(terr_done), tbl[i].exp_terr);
    check($sformatf("r%0d_terr_hold", i), int'(timeoutErr), tbl[i].exp_terr);
    check($sformatf("r%0d_idle", i), int'(busy), 0);
    check($sformatf("r%0d_gap3", i), r4 - s3, tbl[i].exp_gap);
    checkw($sformatf("r%0d_cfg_bit1", i), cfg_cap, exp_cfg);
  endtask

  initial begin
    int k;
    for (int b = 0; b < CB; b++) exp_cfg[8*b +: 8] = 8'(16 + b);
    tbl[0] = '{0, 0, -1, 1'b0, 8'hAA, 0, 2};
    tbl[1] = '{5, 5, -1, 1'b0, 8'hAA, 0, 2};
    tbl[2] = '{0, 0, 3,  1'b0, 8'hA2, 1, TO + 1};
    tbl[3] = '{0, 0, -1, 1'b1, 8'hAA, 0, 2};

    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rdreq", int'(rd_req), 0);
    check("rst_wrreq", int'(wr_req), 0);
    check("rst_pstart", int'(p_start), 0);
    check("rst_terr", int'(timeoutErr), 0);
    check("rst_bidx", int'(bidx), 0);
    checkw("rst_cfg", cfg, '0);
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_idle", int'(busy), 0);

    for (int i = 0; i < 4; i++) run_one(i);

    // reset while a write is pending, then a stray ack after release
    rd_dly = 0; wr_dly = 5; nodone_bit = -1;
    clear_mon();
    pulse_start();
    k = 0;
    while (!wr_req && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("rw_reached_wr", int'(wr_req), 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rw_wrreq_drop", int'(wr_req), 0);
    check("rw_busy", int'(busy), 0);
    check("rw_done", int'(done), 0);
    check("rw_bidx", int'(bidx), 0);
    check("rw_wr_add", int'(wr_add), 0);
    check("rw_wr_data", int'(wr_data), 0);
    checkw("rw_cfg", cfg, '0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    man_wack = 1'b1;
    man_rv   = 1'b1;
    man_rack = 1'b1;
    @(negedge clk);
    man_wack = 1'b0;
    man_rv   = 1'b0;
    man_rack = 1'b0;
    repeat (3) @(negedge clk);
    check("rw_idle", int'(busy), 0);
    check("rw_no_write", wr_cnt, 0);
    check("rw_no_done", done_cnt, 0);
    check("rw_wrreq_low", int'(wr_req), 0);

    run_one(0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/puf_eval_sequencer.md
PUF_EVAL_SEQUENCER -- requirements
Module: puf_eval_sequencer

Interface
REQ-001 Parameter NUM_BITS, default 64, number of PUF response bits evaluated per run; SHALL be a multiple of 8, max 256.
REQ-002 Parameter CFG_BYTES, default 16, configuration bytes per response bit (128 PDL config bits).
REQ-003 Parameter TIMEOUT, default 255, max cycles to wait for pufDone.
REQ-004 Parameters INMEM_ADDRESS_WIDTH, default 17, and OUTMEM_ADDRESS_WIDTH, default 13, memory address widths.
REQ-005 clk  in  1  single clock; all logic on posedge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  run request, sampled in IDLE only.
REQ-008 busy  out  1  high in every state except IDLE.
REQ-009 done  out  1  one-cycle pulse at run completion.
REQ-010 timeoutErr  out  1  sticky flag, any bit timed out this run.
REQ-011 inputMemoryReadReq / inputMemoryReadAck  out / in  1 / 1  read request handshake.
REQ-012 inputMemoryReadAdd  out  INMEM_ADDRESS_WIDTH  read byte address.
REQ-013 inputMemoryReadDataValid / inputMemoryReadData  in / in  1 / 8  returned read data.
REQ-014 outputMemoryWriteReq / outputMemoryWriteAck  out / in  1 / 1  write request handshake.
REQ-015 outputMemoryWriteAdd  out  OUTMEM_ADDRESS_WIDTH  write byte address.
REQ-016 outputMemoryWriteData  out  8  write data.
REQ-017 pufConfig  out  8*CFG_BYTES  PDL configuration for the bit under evaluation.
REQ-018 pufBitIndex  out  8  index of the bit under evaluation.
REQ-019 pufStart  out  1  one-cycle evaluation trigger.
REQ-020 pufDone / pufResponse  in / in  1 / 1  evaluation complete, response bit valid when pufDone=1.

Function
REQ-021 States SHALL be IDLE, RD_REQ, RD_WAIT, EVAL_START, EVAL_WAIT, WR_REQ, FINISH.
REQ-022 IDLE: start=1 -> RD_REQ, bit index 0, byte count 0, timeoutErr cleared, response vector cleared; start ignored in other states.
REQ-023 RD_REQ: inputMemoryReadReq=1, inputMemoryReadAdd=bitIndex*CFG_BYTES+byteCount held stable; req&ack in same cycle -> req drops next cycle, go RD_WAIT.
REQ-024 Only one read outstanding; RD_WAIT waits indefinitely for inputMemoryReadDataValid.
REQ-025 On data valid, byte k SHALL be written to pufConfig[8k+7:8k]; if k<CFG_BYTES-1 -> byteCount+1, RD_REQ; else -> EVAL_START.
REQ-026 EVAL_START: pufStart=1 for exactly one cycle, timeout counter cleared, -> EVAL_WAIT; pufConfig and pufBitIndex stable from EVAL_START until EVAL_WAIT exits.
REQ-027 EVAL_WAIT: pufDone=1 -> response[bitIndex] <= pufResponse; counter reaching TIMEOUT without pufDone -> response[bitIndex] <= 0, timeoutErr <= 1; pufDone on the timeout cycle counts as done, no error.
REQ-028 After EVAL_WAIT exit: bitIndex<NUM_BITS-1 -> bitIndex+1, byteCount 0, RD_REQ; else -> WR_REQ with write address 0.
REQ-029 WR_REQ: outputMemoryWriteReq=1, outputMemoryWriteData=response[8j+7:8j] for address j; add/data held until req&ack; then j+1; after ack of j=NUM_BITS/8-1 req drops next cycle, -> FINISH.
REQ-030 FINISH: done=1 one cycle, -> IDLE; results and timeoutErr remain readable until next start.
REQ-031 pufDone arriving outside EVAL_WAIT SHALL be ignored.
REQ-032 Address arithmetic SHALL be unsigned and truncated to the port width; no wrap occurs at default parameters (max read address 1023).

Reset
REQ-033 reset=1 SHALL asynchronously force IDLE and zero every output, pufConfig, counters, response vector and timeoutErr.
REQ-034 Reset mid-read or mid-write SHALL drop req within the reset cycle; late ack/dataValid after reset release SHALL be ignored in IDLE.

Verification
REQ-035 NUM_BITS=8, memory byte at address n = n, ack same cycle, dataValid 2 cycles later, pufResponse=bitIndex[0] -> 128 reads at addresses 0..127, pufConfig for bit 1 = bytes 0x1F..0x10 (MSB..LSB), one write of 0xAA at address 0, done pulse, timeoutErr=0.
REQ-036 Ack delayed 5 cycles on every read and write -> addresses/data held stable throughout; identical results to REQ-035.
REQ-037 pufDone never asserted for bit 3, TIMEOUT=10 -> EVAL_WAIT exits after 10 cycles, response bit 3 = 0, timeoutErr=1 at done, clears on next start.
REQ-038 start pulsed while busy and pufDone pulsed during RD_WAIT -> no restart, no response change.
REQ-039 reset asserted during WR_REQ with ack arriving the cycle after release -> all outputs 0, state IDLE, no write, no done.
